seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for a multi-digit 7-segment display.
//  One shared BCD->segment decoder drives the segments; this block selects one digit at a time.
//  It presents that digit's BCD value to the decoder and drives the active-low digit enables.
//  New display data arrives over a valid/ready handshake and is committed only at a frame boundary (no tearing).

---
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display.
// Digits are lit one at a time, with a blanking gap before each. New data is committed only at a frame boundary.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    lz_blank,
    output logic [3:0]              value,
    output logic                    blank,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_done
);
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [3:0]              value_q, value_d;
    logic                    blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   sel_n_q, sel_n_d;
    logic                    frame_done_q, frame_done_d;
    logic                    frame_end;
    logic                    upper_nz;

    assign load_ready  = !pending_q && !rst;
    assign value       = value_q;
    assign blank       = blank_q;
    assign digit_sel_n = sel_n_q;
    assign frame_done  = frame_done_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        frame_end = 1'b0;
        upper_nz  = 1'b0;
        sel_n_d   = '1;
        value_d   = 4'd0;
        blank_d   = 1'b1;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IW'(NUM_DIGITS - 1)) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Commit before accept: ready is low whenever pending is set, so both never coincide.
        if (frame_end && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load_valid && load_ready) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        // Outputs are computed from next state so they line up with the registered state.
        if (state_d == ST_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IW'(i)) begin
                    sel_n_d[i] = 1'b0;
                    value_d    = active_d[4*i +: 4];
                end
                if (IW'(i) >= idx_d && active_d[4*i +: 4] != 4'd0)
                    upper_nz = 1'b1;
            end
            blank_d = (value_d > 4'd9) || (lz_blank && idx_d != '0 && !upper_nz);
        end
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            value_q      <= 4'd0;
            blank_q      <= 1'b1;
            sel_n_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            value_q      <= value_d;
            blank_q      <= blank_d;
            sel_n_q      <= sel_n_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
